// File: rtl/reg_bank_rw.sv
// reg_bank_rw: DEPTH x WIDTH register bank with one write port, two
// registered read ports (1-cycle latency) and a sequential clear engine
// that zeroes one entry per cycle while busy is high.
//
// Optional feature: define REG_BANK_BYPASS_EN to forward same-cycle write
// data to a read port whose address matches the write address. Without it
// the read returns the entry's contents from before the write.
//
// Handshake: there is no back-pressure. A write or read request is taken in
// any IDLE cycle in which its enable is sampled high on the rising edge. In
// CLEAR, every request is ignored. rd_valid marks the single cycle in which
// rd_data_a/rd_data_b carry a fresh result. At other times the read outputs
// hold their last values.
module reg_bank_rw #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              busy,
    output logic              dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0]    wr_sel;
    logic [DEPTH-1:0]    clr_sel;
    logic                wr_fire;
    logic                rd_fire;
    logic [WIDTH-1:0]    rd_a_d, rd_b_d;
    logic [WIDTH-1:0]    rd_data_a_q, rd_data_b_q;
    logic                rd_valid_q;

    // In IDLE, a clear request wins over a write in the same cycle. A read
    // in that cycle still completes and returns the data from before the clear.
    assign wr_fire = (state_q == ST_IDLE) && wr_en && !clr_req;
    assign rd_fire = (state_q == ST_IDLE) && rd_en;

    // State register and clear counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. CLEAR lasts exactly DEPTH cycles and the counter wraps back to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // One-hot decode of the write address and of the entry being cleared.
    always_comb begin
        wr_sel  = '0;
        clr_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel[i]  = wr_fire && (wr_addr == ADDR_W'(i));
            clr_sel[i] = (state_q == ST_CLEAR) && (cnt_q == ADDR_W'(i));
        end
    end

    // Storage entries. Each one loads only when its own decoded enable is high.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        // Entry g: the clear zeroes it, otherwise it takes the write data when selected.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[g] <= '0;
            end else if (clr_sel[g]) begin
                mem_q[g] <= '0;
            end else if (wr_sel[g]) begin
                mem_q[g] <= wr_data;
            end
        end
    end

    // Read muxes, with optional forwarding of same-cycle write data.
    always_comb begin
        rd_a_d = mem_q[rd_addr_a];
        rd_b_d = mem_q[rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
        if (wr_fire && (wr_addr == rd_addr_a)) begin
            rd_a_d = wr_data;
        end
        if (wr_fire && (wr_addr == rd_addr_b)) begin
            rd_b_d = wr_data;
        end
`else
        rd_a_d = rd_a_d;
        rd_b_d = rd_b_d;
`endif
    end

    // Registered read ports. The data holds while no read is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_a_q <= rd_a_d;
                rd_data_b_q <= rd_b_d;
            end
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = (state_q == ST_CLEAR);
    assign dbg_state = state_q;

endmodule

// File: doc/reg_bank_rw.md
REG_BANK_RW -- requirements
Module: reg_bank_rw

Interface
REQ-001 Parameter WIDTH, default 8, the data width of each entry in bits.
REQ-002 Parameter ADDR_W, default 2, the address width; DEPTH = 2**ADDR_W entries.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write request for the current cycle.
REQ-006 wr_addr  input  ADDR_W  write entry index.
REQ-007 wr_data  input  WIDTH  write data.
REQ-008 rd_en  input  1  read request on both read ports for the current cycle.
REQ-009 rd_addr_a  input  ADDR_W  port A read index.
REQ-010 rd_addr_b  input  ADDR_W  port B read index.
REQ-011 rd_data_a  output  WIDTH  registered port A read data.
REQ-012 rd_data_b  output  WIDTH  registered port B read data.
REQ-013 rd_valid  output  1  high for one cycle when rd_data_a and rd_data_b hold fresh read results.
REQ-014 clr_req  input  1  request to zero every entry.
REQ-015 busy  output  1  high while a clear sequence is in progress.

Function
REQ-016 Storage SHALL be DEPTH registers of WIDTH bits; the write address is decoded one-hot, and each entry loads wr_data only when its decoded enable is high.
REQ-017 A write accepted in cycle N SHALL be visible in the entry from cycle N+1.
REQ-018 Reads SHALL have 1-cycle latency: rd_en sampled high in cycle N drives the data muxed from rd_addr_a and rd_addr_b onto rd_data_a and rd_data_b, with rd_valid high, in cycle N+1.
REQ-019 When rd_en is low, rd_data_a and rd_data_b SHALL hold their previous values and rd_valid SHALL be 0.
REQ-020 The FSM SHALL have two states: IDLE and CLEAR.
REQ-021 IDLE -> CLEAR when clr_req is sampled high; the clear counter starts at 0.
REQ-022 In CLEAR, the entry addressed by the counter SHALL be zeroed each cycle and the counter incremented, so the sequence takes exactly DEPTH cycles.
REQ-023 CLEAR -> IDLE on the cycle the counter clears entry DEPTH-1; the counter wraps to 0.
REQ-024 busy SHALL be 1 in every CLEAR cycle and 0 in IDLE.
REQ-025 While busy, wr_en, rd_en and clr_req SHALL be ignored: no write occurs, rd_valid stays 0 and read outputs hold.
REQ-026 clr_req and wr_en high together in IDLE: the clear takes priority and the write is dropped.
REQ-027 rd_en high in the same IDLE cycle as clr_req SHALL still complete, returning the pre-clear data.
REQ-028 A read and a write to the same address in the same cycle SHALL return the old data unless the bypass option is compiled in (REQ-033).
REQ-029 Both read ports SHALL be able to address the same entry simultaneously without conflict.

Reset
REQ-030 On rst_n low, asynchronously: all entries = 0, rd_data_a = rd_data_b = 0, rd_valid = 0, busy = 0, FSM = IDLE, clear counter = 0.
REQ-031 Reset asserted mid-clear SHALL abort the sequence; after release the block is IDLE with all entries 0.
REQ-032 The first clock edge after rst_n deasserts SHALL accept a write or read normally.

Configuration
REQ-033 Macro REG_BANK_BYPASS_EN: when defined, a same-cycle read and write to an equal address SHALL return wr_data on that read port at N+1; when undefined, the read returns the entry's prior contents; all other behaviour is identical.

Verification (WIDTH=8, ADDR_W=2)
REQ-034 Reset, write 0xA5 @1, then read A=1, B=1 -> rd_data_a = rd_data_b = 0xA5 with rd_valid = 1 one cycle after rd_en.
REQ-035 Write 0x11,0x22,0x33,0x44 to entries 0..3, pulse clr_req -> busy high for exactly 4 cycles; a subsequent read of any entry returns 0x00.
REQ-036 During busy, assert wr_en @2 = 0xFF and rd_en -> entry 2 unchanged, rd_valid stays 0.
REQ-037 Entry 3 = 0x10, same cycle write 0x77 @3 and read A=3 -> rd_data_a = 0x10 without the macro, 0x77 with REG_BANK_BYPASS_EN.
REQ-038 Assert rst_n low on the 2nd cycle of a clear -> busy = 0 immediately, all entries and outputs 0 after release.
REQ-039 clr_req and wr_en 0x5A @0 in the same IDLE cycle -> after the clear completes, entry 0 reads 0x00.
